// File: rtl/rom_fetch_responder.sv
// rom_fetch_responder: answers core instruction fetches by reading
// two 16-bit half-words from external memory and returning one word.
module rom_fetch_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          MEM_AW    = 22,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       rom_addr,
  input  logic              rom_re,
  output logic [31:0]       rom_out,
  output logic              rom_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              fault
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RESP,
    GAP
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT);

  state_t            state_q, state_d;
  logic [31:0]       rom_out_q, rom_out_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              flag_q, flag_d;
  logic [15:0]       lo_q, lo_d;
  logic [15:0]       timer_q, timer_d;

  logic [31:0] off;
  logic        ack;
  logic        bad_req;
  logic        unused_off;

  assign off        = rom_addr - ADDR_BASE;
  assign ack        = mem_ack && mem_rd_q;
  assign bad_req    = (rom_addr[1:0] != 2'b00) || (|off[31:MEM_AW+1]);
  assign unused_off = ^off[1:0];

  // Next-state and datapath updates for the fetch sequence.
  always_comb begin
    state_d    = state_q;
    rom_out_d  = rom_out_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    flag_d     = flag_q;
    lo_d       = lo_q;
    timer_d    = timer_q;
    unique case (state_q)
      IDLE: begin
        if (rom_re) begin
          timer_d = 16'd0;
          if (bad_req) begin
            rom_out_d = NOP_WORD;
            flag_d    = 1'b1;
            state_d   = RESP;
          end else begin
            flag_d     = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = {off[MEM_AW:2], 1'b0};
            state_d    = RD_LO;
          end
        end
      end
      RD_LO: begin
        if (ack) begin
          lo_d          = mem_rdata;
          timer_d       = 16'd0;
          mem_addr_d[0] = 1'b1;
          state_d       = RD_HI;
        end else if (timer_q == TMAX) begin
          mem_rd_d  = 1'b0;
          rom_out_d = NOP_WORD;
          flag_d    = 1'b1;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RD_HI: begin
        if (ack) begin
          mem_rd_d  = 1'b0;
          rom_out_d = {mem_rdata, lo_q};
          state_d   = RESP;
        end else if (timer_q == TMAX) begin
          mem_rd_d  = 1'b0;
          rom_out_d = NOP_WORD;
          flag_d    = 1'b1;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered memory-side outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rom_out_q  <= 32'd0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      flag_q     <= 1'b0;
      lo_q       <= 16'd0;
      timer_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      rom_out_q  <= rom_out_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      flag_q     <= flag_d;
      lo_q       <= lo_d;
      timer_q    <= timer_d;
    end
  end

  assign rom_out  = rom_out_q;
  assign rom_oe   = (state_q == RESP);
  assign fault    = (state_q == RESP) && flag_q;
  assign busy     = (state_q != IDLE);
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_rom_fetch_responder.sv
// tb_rom_fetch_responder: directed checks of the fetch responder,
// including faults, timeout, back-to-back requests and mid-fetch reset.
module tb_rom_fetch_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] rom_addr;
  logic        rom_re;
  logic [31:0] rom_out;
  logic        rom_oe;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        fault;

  logic [31:0] b_rom_addr;
  logic        b_rom_re;
  logic [31:0] b_rom_out;
  logic        b_rom_oe;
  logic [21:0] b_mem_addr;
  logic        b_mem_rd;
  logic        b_mem_ack;
  logic [15:0] b_mem_rdata;
  logic        b_busy;
  logic        b_fault;

  int tests = 0;
  int fails = 0;

  rom_fetch_responder dut (
    .clk       (clk),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_re    (rom_re),
    .rom_out   (rom_out),
    .rom_oe    (rom_oe),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .fault     (fault)
  );

  rom_fetch_responder #(.TIMEOUT(4)) dut_t (
    .clk       (clk),
    .reset     (reset),
    .rom_addr  (b_rom_addr),
    .rom_re    (b_rom_re),
    .rom_out   (b_rom_out),
    .rom_oe    (b_rom_oe),
    .mem_addr  (b_mem_addr),
    .mem_rd    (b_mem_rd),
    .mem_ack   (b_mem_ack),
    .mem_rdata (b_mem_rdata),
    .busy      (b_busy),
    .fault     (b_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_mem();
    mem_rdata = mem_addr[15:0] ^ 16'h5A5A;
    tick();
  endtask

  logic [31:0] exp_t5 [3];
  int          n;
  logic        prev_oe;

  initial begin
    exp_t5[0] = 32'h5A53_5A52;
    exp_t5[1] = 32'h5A51_5A50;
    exp_t5[2] = 32'h5A57_5A56;

    reset       = 1'b1;
    rom_addr    = 32'd0;
    rom_re      = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 16'd0;
    b_rom_addr  = 32'd0;
    b_rom_re    = 1'b0;
    b_mem_ack   = 1'b0;
    b_mem_rdata = 16'd0;
    tick();
    tick();
    chk("rst_rom_out", rom_out, 32'd0);
    chk("rst_rom_oe", 32'(rom_oe), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    tick();

    mem_ack = 1'b1;
    tick();
    chk("idle_ack_ignored", 32'(busy), 32'd0);
    mem_ack = 1'b0;

    // T1 zero-wait fetch
    rom_addr = 32'h8000_0004;
    rom_re   = 1'b1;
    tick();
    chk("t1_rd_lo", 32'(mem_rd), 32'd1);
    chk("t1_addr_lo", 32'(mem_addr), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    rom_re    = 1'b0;
    rom_addr  = 32'h8000_0100;
    mem_ack   = 1'b1;
    mem_rdata = 16'h0093;
    tick();
    chk("t1_rd_hi", 32'(mem_rd), 32'd1);
    chk("t1_addr_hi", 32'(mem_addr), 32'd3);
    chk("t1_no_oe", 32'(rom_oe), 32'd0);
    mem_rdata = 16'h0010;
    tick();
    mem_ack = 1'b0;
    chk("t1_oe", 32'(rom_oe), 32'd1);
    chk("t1_out", rom_out, 32'h0010_0093);
    chk("t1_fault", 32'(fault), 32'd0);
    chk("t1_rd_drop", 32'(mem_rd), 32'd0);
    tick();
    chk("t1_gap_oe", 32'(rom_oe), 32'd0);
    chk("t1_gap_busy", 32'(busy), 32'd1);
    chk("t1_hold", rom_out, 32'h0010_0093);
    tick();
    chk("t1_idle", 32'(busy), 32'd0);

    // T2 delayed acks
    rom_addr = 32'h8000_0008;
    rom_re   = 1'b1;
    tick();
    rom_re = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_lo_rd", 32'(mem_rd), 32'd1);
      chk("t2_lo_addr", 32'(mem_addr), 32'd4);
      chk("t2_lo_busy", 32'(busy), 32'd1);
      chk("t2_lo_oe", 32'(rom_oe), 32'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("t2_hi_addr0", 32'(mem_addr), 32'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hi_rd", 32'(mem_rd), 32'd1);
      chk("t2_hi_addr", 32'(mem_addr), 32'd5);
      chk("t2_hi_busy", 32'(busy), 32'd1);
      chk("t2_hi_oe", 32'(rom_oe), 32'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    chk("t2_oe", 32'(rom_oe), 32'd1);
    chk("t2_out", rom_out, 32'h1234_BEEF);
    chk("t2_fault", 32'(fault), 32'd0);
    tick();
    chk("t2_gap_oe", 32'(rom_oe), 32'd0);
    tick();
    chk("t2_idle_oe", 32'(rom_oe), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // T3 misaligned, wrapped and boundary addresses
    rom_addr = 32'h8000_0002;
    rom_re   = 1'b1;
    tick();
    rom_re = 1'b0;
    chk("t3a_oe", 32'(rom_oe), 32'd1);
    chk("t3a_fault", 32'(fault), 32'd1);
    chk("t3a_out", rom_out, 32'h0000_0013);
    chk("t3a_rd", 32'(mem_rd), 32'd0);
    tick();
    chk("t3a_gap_fault", 32'(fault), 32'd0);
    tick();
    rom_addr = 32'h7FFF_FFFC;
    rom_re   = 1'b1;
    tick();
    rom_re = 1'b0;
    chk("t3b_oe", 32'(rom_oe), 32'd1);
    chk("t3b_fault", 32'(fault), 32'd1);
    chk("t3b_out", rom_out, 32'h0000_0013);
    chk("t3b_rd", 32'(mem_rd), 32'd0);
    tick();
    tick();
    rom_addr = 32'h8080_0000;
    rom_re   = 1'b1;
    tick();
    rom_re = 1'b0;
    chk("t3c_fault", 32'(fault), 32'd1);
    chk("t3c_rd", 32'(mem_rd), 32'd0);
    tick();
    tick();
    rom_addr = 32'h807F_FFFC;
    rom_re   = 1'b1;
    tick();
    rom_re  = 1'b0;
    mem_ack = 1'b1;
    chk("t3d_addr_lo", 32'(mem_addr), 32'h003F_FFFE);
    step_mem();
    chk("t3d_addr_hi", 32'(mem_addr), 32'h003F_FFFF);
    step_mem();
    mem_ack = 1'b0;
    chk("t3d_oe", 32'(rom_oe), 32'd1);
    chk("t3d_fault", 32'(fault), 32'd0);
    chk("t3d_out", rom_out, 32'hA5A5_A5A4);
    tick();
    tick();

    // T4 timeout with TIMEOUT=4
    b_rom_addr = 32'h8000_0000;
    b_rom_re   = 1'b1;
    tick();
    b_rom_re = 1'b0;
    chk("t4_rd0", 32'(b_mem_rd), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_wait_rd", 32'(b_mem_rd), 32'd1);
      chk("t4_wait_oe", 32'(b_rom_oe), 32'd0);
    end
    tick();
    chk("t4_rd_drop", 32'(b_mem_rd), 32'd0);
    chk("t4_oe", 32'(b_rom_oe), 32'd1);
    chk("t4_fault", 32'(b_fault), 32'd1);
    chk("t4_out", b_rom_out, 32'h0000_0013);
    tick();
    chk("t4_gap_busy", 32'(b_busy), 32'd1);
    chk("t4_gap_oe", 32'(b_rom_oe), 32'd0);
    tick();
    chk("t4_idle", 32'(b_busy), 32'd0);

    // ack on the expiry cycle wins over the timeout
    b_rom_re = 1'b1;
    tick();
    b_rom_re = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4b_still_rd", 32'(b_mem_rd), 32'd1);
    b_mem_ack   = 1'b1;
    b_mem_rdata = 16'h0513;
    tick();
    chk("t4b_addr_hi", 32'(b_mem_addr), 32'd1);
    chk("t4b_no_oe", 32'(b_rom_oe), 32'd0);
    b_mem_rdata = 16'h00A0;
    tick();
    b_mem_ack = 1'b0;
    chk("t4b_oe", 32'(b_rom_oe), 32'd1);
    chk("t4b_fault", 32'(b_fault), 32'd0);
    chk("t4b_out", b_rom_out, 32'h00A0_0513);
    tick();
    tick();

    // T5 rom_re held high, address stepping on each strobe
    rom_addr = 32'h8000_0010;
    rom_re   = 1'b1;
    mem_ack  = 1'b1;
    n        = 0;
    prev_oe  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step_mem();
      chk("t5_no_dup", 32'(rom_oe && prev_oe), 32'd0);
      prev_oe = rom_oe;
      if (rom_oe) begin
        chk("t5_oe_cycle", 32'(i), 32'(2 + 5 * n));
        chk("t5_out", rom_out, exp_t5[n % 3]);
        chk("t5_fault", 32'(fault), 32'd0);
        n++;
        rom_addr = rom_addr + 32'd4;
      end
    end
    rom_re = 1'b0;
    chk("t5_count", 32'(n), 32'd3);
    step_mem();
    chk("t5_idle", 32'(busy), 32'd0);

    // T6 reset while in RD_HI
    rom_addr = 32'h8000_0020;
    rom_re   = 1'b1;
    mem_ack  = 1'b1;
    step_mem();
    rom_re  = 1'b0;
    step_mem();
    mem_ack = 1'b0;
    chk("t6_in_hi", 32'(mem_addr), 32'h0000_0011);
    tick();
    chk("t6_pre_rd", 32'(mem_rd), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rd_async", 32'(mem_rd), 32'd0);
    chk("t6_out_clr", rom_out, 32'd0);
    chk("t6_oe", 32'(rom_oe), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_resp", 32'(rom_oe), 32'd0);
    end
    rom_addr = 32'h8000_0024;
    rom_re   = 1'b1;
    mem_ack  = 1'b1;
    step_mem();
    rom_re = 1'b0;
    chk("t6_new_addr", 32'(mem_addr), 32'h0000_0012);
    step_mem();
    step_mem();
    mem_ack = 1'b0;
    chk("t6_new_oe", 32'(rom_oe), 32'd1);
    chk("t6_new_out", rom_out, 32'h5A49_5A48);
    chk("t6_new_fault", 32'(fault), 32'd0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
